mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the MULT and DIV instructions. It sits directly downstream of the ALU operand-select muxes and consumes A (rs) and the selected B operand (rt). It iterates one bit per cycle and writes the 64-bit product, or the quotient and remainder, into the HI/LO registers. The control FSM starts it with a one-cycle pulse and waits on busy/done.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit writing HI/LO for MULT and DIV.
// Radix-2 Booth multiply and restoring divide on magnitudes, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] booth_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [2*WIDTH:0] div_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

    // Multiply layout: acc = {p_hi, p_lo, q-1}. The add is done one bit wider
    // so that +/- (-2^(W-1)) cannot overflow before the arithmetic shift.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = booth_sum - {opnd[WIDTH-1], opnd};
            default: booth_sum = booth_sum;
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    // Divide layout: acc = {0, remainder, quotient/dividend}.
    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (!div_trial[WIDTH]) begin
            div_next = {1'b0, div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {1'b0, div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        a_mag  = a[WIDTH-1] ? -a : a;
        b_mag  = b[WIDTH-1] ? -b : b;
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fin_lo = is_div ? (neg_q ? -quot : quot) : acc[WIDTH:1];
        fin_hi = is_div ? (neg_r ? -rem : rem) : acc[2*WIDTH:WIDTH+1];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mult) begin
                        acc    <= {{WIDTH{1'b0}}, b, 1'b0};
                        opnd   <= a;
                        is_div <= 1'b0;
                        cnt    <= '0;
                        state  <= S_MULT;
                    end else if (start_div) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            acc    <= {{(WIDTH+1){1'b0}}, a_mag};
                            opnd   <= b_mag;
                            is_div <= 1'b1;
                            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r  <= a[WIDTH-1];
                            cnt    <= '0;
                            state  <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc <= booth_next;
                    if (cnt == CNT_W'(WIDTH-1)) state <= S_FIN;
                    else                        cnt   <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_next;
                    if (cnt == CNT_W'(WIDTH-1)) state <= S_FIN;
                    else                        cnt   <= cnt + 1'b1;
                end
                S_FIN: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and
// arrival time; a negedge monitor pops and compares on done/div_zero.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .start_mult(start_mult),
        .start_div(start_div),
        .a(a),
        .b(b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    typedef struct {
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
        time         t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (done === 1'b1 || div_zero === 1'b1)) begin
            check("done_dz_exclusive", done & div_zero, 0);
            check("busy_at_output", busy, 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: done=%b div_zero=%b with nothing expected", done, div_zero);
            end else begin
                mon_e = sb.pop_front();
                check("kind_div_zero", div_zero, mon_e.dz);
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("arrival_time", $time, mon_e.t);
            end
        end
    end

    // Drive a start pulse; start edge N is the posedge after the drive.
    task automatic issue(input bit m, input bit d, input logic [31:0] av, input logic [31:0] bv,
                         input bit push, input bit exp_dz, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        a = av;
        b = bv;
        @(posedge clk);
        if (push) begin
            e.dz = exp_dz;
            e.hi = ehi;
            e.lo = elo;
            e.t  = $time + (exp_dz ? 5 : 335);
            sb.push_back(e);
        end
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h0BADF00D;
        check("busy_after_start", busy, !exp_dz);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
        reset = 1'b0;

        issue(1, 0, 32'd7,        32'hFFFFFFFD, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB); drain();
        issue(1, 0, 32'h80000000, 32'h80000000, 1, 0, 32'h40000000, 32'h00000000); drain();
        issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'h00000000, 32'h00000001); drain();
        issue(1, 0, 32'h7FFFFFFF, 32'h80000000, 1, 0, 32'hC0000000, 32'h80000000); drain();
        issue(0, 1, 32'hFFFFFFF9, 32'd2,        1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD); drain();
        issue(0, 1, 32'd7,        32'hFFFFFFFE, 1, 0, 32'h00000001, 32'hFFFFFFFD); drain();
        issue(0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 1, 0, 32'hFFFFFFFF, 32'h00000003); drain();
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h00000000, 32'h80000000); drain();

        // 1105 / 32 = 34 rem 17 preloads hi=0x11, lo=0x22 before the zero divide.
        issue(0, 1, 32'h451, 32'h20, 1, 0, 32'h11, 32'h22); drain();
        issue(0, 1, 32'h1234, 32'h0, 1, 1, 32'h11, 32'h22); drain();
        check("dz_hold_hi", hi, 32'h11);
        check("dz_hold_lo", lo, 32'h22);
        check("dz_busy", busy, 0);

        // Starts and operand changes while busy must be ignored.
        issue(1, 0, 32'd3, 32'd5, 1, 0, 32'h0, 32'd15);
        repeat (9) @(negedge clk);
        start_div = 1'b1; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start_div = 1'b0;
        repeat (9) @(negedge clk);
        start_mult = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        drain();

        issue(1, 1, 32'd4, 32'd2, 1, 0, 32'h0, 32'd8); drain();

        issue(0, 1, 32'd100, 32'd7, 0, 0, 32'h0, 32'h0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", busy, 0);

        issue(1, 0, 32'd6, 32'd7, 1, 0, 32'h0, 32'd42); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
